// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
//   Shares one pipelined 4x4 unsigned multiplier among NREQ requesters.
//   A round-robin arbiter grants at most one requester per cycle and steers
//   its operands into the multiplier. A tag pipeline carries the winner's ID
//   so that each product comes back with a one-hot response strobe.
//
//   Handshake (req/gnt): a requester raises req and holds req plus its operand
//   nibbles stable until it sees gnt high in the same cycle. gnt is the
//   acceptance: after that edge the requester may drop or change req. There is
//   no response back-pressure; rsp_valid fires exactly LAT cycles after gnt
//   and must be taken by the consumer on that cycle.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   enable     in   grants allowed when high; in-flight ops always complete
//   req        in   [NREQ]    per-requester request, level-sensitive
//   a_in       in   [4*NREQ]  operand A, requester i at [4i+3:4i]
//   b_in       in   [4*NREQ]  operand B, same packing
//   gnt        out  [NREQ]    one-hot grant, combinational
//   rsp_valid  out  [NREQ]    one-hot result strobe, from registered tags
//   rsp_p      out  [8]       product, straight from the multiplier
//   busy       out            any tag in the pipeline valid
//   issue_cnt  out  [CNTW]    total grants issued, wraps
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// multiplier
//   Pipelined 4x4 unsigned multiplier with LAT register stages between the
//   operand inputs and p_o. All stages clear on reset so p_o reads 0.
// Ports
//   clk    in   clock
//   reset  in   asynchronous, active-low reset
//   a_i    in   [4] operand A
//   b_i    in   [4] operand B
//   p_o    out  [8] product, LAT cycles after the operands
// -----------------------------------------------------------------------------
module multiplier #(
    parameter int LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] p_o
);

    logic [7:0] p_q [LAT];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < LAT; k++) p_q[k] <= '0;
        end else begin
            p_q[0] <= {4'b0000, a_i} * {4'b0000, b_i};
            for (int k = 1; k < LAT; k++) p_q[k] <= p_q[k-1];
        end
    end

    assign p_o = p_q[LAT-1];

endmodule

module mult_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 2,
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] a_in,
    input  logic [4*NREQ-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [7:0]        rsp_p,
    output logic              busy,
    output logic [CNTW-1:0]   issue_cnt
);

    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int IDXW = PTRW + 1;

    logic [PTRW-1:0] ptr_q, ptr_d;
    logic [CNTW-1:0] issue_cnt_q, issue_cnt_d;
    logic            tag_v_q  [LAT];
    logic [PTRW-1:0] tag_id_q [LAT];

    logic [IDXW-1:0] scan_idx;
    logic [PTRW-1:0] win;
    logic            found;
    logic            grant;
    logic [3:0]      a_mux, b_mux;

    // Round-robin scan: first asserted req at or above ptr, wrapping.
    always_comb begin
        scan_idx = '0;
        win      = '0;
        found    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = {1'b0, ptr_q} + IDXW'(k);
            if (scan_idx >= IDXW'(NREQ)) scan_idx = scan_idx - IDXW'(NREQ);
            if (!found && req[scan_idx[PTRW-1:0]]) begin
                found = 1'b1;
                win   = scan_idx[PTRW-1:0];
            end
        end
    end

    // Gating with reset keeps gnt at 0 while the block is held in reset, so
    // no requester believes it was accepted by a pipeline that is clearing.
    assign grant = found & enable & reset;

    always_comb begin
        gnt   = '0;
        a_mux = '0;
        b_mux = '0;
        if (grant) gnt[win] = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (grant && (win == PTRW'(i))) begin
                a_mux = a_in[4*i +: 4];
                b_mux = b_in[4*i +: 4];
            end
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        issue_cnt_d = issue_cnt_q;
        if (grant) begin
            ptr_d       = (win == PTRW'(NREQ-1)) ? '0 : win + PTRW'(1);
            issue_cnt_d = issue_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q       <= '0;
            issue_cnt_q <= '0;
            for (int k = 0; k < LAT; k++) begin
                tag_v_q[k]  <= 1'b0;
                tag_id_q[k] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            issue_cnt_q <= issue_cnt_d;
            tag_v_q[0]  <= grant;
            tag_id_q[0] <= win;
            for (int k = 1; k < LAT; k++) begin
                tag_v_q[k]  <= tag_v_q[k-1];
                tag_id_q[k] <= tag_id_q[k-1];
            end
        end
    end

    // The last tag stage lines up with the multiplier output register.
    always_comb begin
        rsp_valid = '0;
        if (tag_v_q[LAT-1]) rsp_valid[tag_id_q[LAT-1]] = 1'b1;
    end

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < LAT; k++) busy = busy | tag_v_q[k];
    end

    assign issue_cnt = issue_cnt_q;

    multiplier #(.LAT(LAT)) u_mult (
        .clk   (clk),
        .reset (reset),
        .a_i   (a_mux),
        .b_i   (b_mux),
        .p_o   (rsp_p)
    );

endmodule

// File: tb/tb_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_arbiter
//   Directed bench for mult_arbiter (NREQ=4, LAT=2, CNTW=16). Inputs change on
//   the falling edge; outputs are sampled 1 time unit later, so combinational
//   gnt reflects the new inputs and registered outputs reflect the last edge.
// -----------------------------------------------------------------------------
module tb_mult_arbiter;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [3:0]  req;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [3:0]  gnt;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_p;
    logic        busy;
    logic [15:0] issue_cnt;

    int vectors;
    int miscompares;

    mult_arbiter #(.NREQ(4), .LAT(2), .CNTW(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_p     (rsp_p),
        .busy      (busy),
        .issue_cnt (issue_cnt)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int i, input int a, input int b);
        logic [3:0] av;
        logic [3:0] bv;
        av = a[3:0];
        bv = b[3:0];
        a_in[4*i +: 4] = av;
        b_in[4*i +: 4] = bv;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        req   = '0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    logic [3:0] pv [2];
    logic [7:0] pp [2];
    logic [3:0] exp_g;
    int         pair;

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset  = 1'b0;
        enable = 1'b0;
        req    = '0;
        a_in   = '0;
        b_in   = '0;

        // ---- held in reset ----
        @(negedge clk); #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_p", rsp_p, 0);
        chk("rst_busy", busy, 0);
        chk("rst_issue_cnt", issue_cnt, 0);

        // ---- release, no requests ----
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            chk("idle_gnt", gnt, 0);
            chk("idle_rsp_valid", rsp_valid, 0);
            chk("idle_busy", busy, 0);
            chk("idle_issue_cnt", issue_cnt, 0);
        end

        // ---- single request: req[2], 9*7 ----
        @(negedge clk);
        req = 4'b0100;
        set_ops(2, 9, 7);
        #1;
        chk("single_gnt", gnt, 4'b0100);
        @(negedge clk);
        req = '0;
        #1;
        chk("single_gnt_drop", gnt, 0);
        chk("single_busy_t1", busy, 1);
        chk("single_rsp_t1", rsp_valid, 0);
        chk("single_cnt", issue_cnt, 1);
        @(negedge clk); #1;
        chk("single_rsp_t2", rsp_valid, 4'b0100);
        chk("single_p", rsp_p, 63);
        chk("single_busy_t2", busy, 1);
        @(negedge clk); #1;
        chk("single_rsp_t3", rsp_valid, 0);
        chk("single_busy_t3", busy, 0);

        // ---- reset while an op is in flight (ptr is now 3) ----
        @(negedge clk);
        req = 4'b1010;
        set_ops(3, 5, 5);
        set_ops(1, 2, 3);
        #1;
        chk("rstfl_gnt", gnt, 4'b1000);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rstfl_async_gnt", gnt, 0);
        chk("rstfl_async_busy", busy, 0);
        chk("rstfl_async_rsp", rsp_valid, 0);
        chk("rstfl_async_cnt", issue_cnt, 0);
        chk("rstfl_async_p", rsp_p, 0);
        @(negedge clk);
        req   = '0;
        reset = 1'b1;
        #1;
        chk("rstfl_rsp_a", rsp_valid, 0);
        @(negedge clk); #1;
        chk("rstfl_rsp_b", rsp_valid, 0);
        chk("rstfl_busy", busy, 0);
        @(negedge clk);
        req = 4'b1010;
        #1;
        chk("rstfl_restart_gnt", gnt, 4'b0010);
        @(negedge clk);
        req = '0;
        @(negedge clk); #1;
        chk("rstfl_restart_rsp", rsp_valid, 4'b0010);
        chk("rstfl_restart_p", rsp_p, 6);

        // ---- all requesters held: a=i+1, b=15 ----
        do_reset();
        for (int i = 0; i < 4; i++) set_ops(i, i + 1, 15);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            req = (k < 5) ? 4'b1111 : 4'b0000;
            #1;
            exp_g = (k < 5) ? (4'b0001 << (k % 4)) : 4'b0000;
            chk("rr_gnt", gnt, exp_g);
            if (k >= 2) begin
                chk("rr_rsp_valid", rsp_valid, 4'b0001 << ((k - 2) % 4));
                chk("rr_p", rsp_p, ((k - 2) % 4 + 1) * 15);
            end
        end
        chk("rr_cnt", issue_cnt, 5);

        // ---- move ptr to 2 with one grant to requester 1, then drain ----
        @(negedge clk);
        req = 4'b0010;
        #1;
        chk("setup_gnt", gnt, 4'b0010);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req = '0;
        end
        #1;
        chk("setup_busy", busy, 0);

        // ---- req[1] and req[3] alternate; sweep all pairs through req 1 ----
        set_ops(3, 15, 15);
        pv[0] = '0; pv[1] = '0;
        pp[0] = '0; pp[1] = '0;
        for (int s = 0; s < 514; s++) begin
            @(negedge clk);
            pair = s >> 1;
            req  = (s < 512) ? 4'b1010 : 4'b0000;
            if (s < 512) set_ops(1, pair >> 4, pair & 15);
            #1;
            if (s >= 512)          exp_g = 4'b0000;
            else if ((s & 1) == 0) exp_g = 4'b1000;
            else                   exp_g = 4'b0010;
            chk("sweep_gnt", gnt, exp_g);
            if (s >= 2) begin
                chk("sweep_rsp_valid", rsp_valid, pv[1]);
                if (pv[1] != 0) chk("sweep_p", rsp_p, pp[1]);
            end
            pv[1] = pv[0];
            pp[1] = pp[0];
            pv[0] = exp_g;
            if (exp_g == 4'b1000) pp[0] = 8'd225;
            else                  pp[0] = 8'((pair >> 4) * (pair & 15));
        end
        chk("sweep_cnt", issue_cnt, 518);

        // ---- enable dropped after a grant (ptr is 2) ----
        @(negedge clk);
        req = 4'b0001;
        set_ops(0, 3, 5);
        #1;
        chk("en_gnt", gnt, 4'b0001);
        @(negedge clk);
        enable = 1'b0;
        req    = 4'b1111;
        #1;
        chk("en_off_gnt_a", gnt, 0);
        chk("en_busy_a", busy, 1);
        @(negedge clk); #1;
        chk("en_off_gnt_b", gnt, 0);
        chk("en_busy_b", busy, 1);
        chk("en_rsp", rsp_valid, 4'b0001);
        chk("en_p", rsp_p, 15);
        @(negedge clk); #1;
        chk("en_off_gnt_c", gnt, 0);
        chk("en_busy_c", busy, 0);
        chk("en_rsp_c", rsp_valid, 0);
        @(negedge clk);
        enable = 1'b1;
        #1;
        chk("en_resume_gnt", gnt, 4'b0010);
        @(negedge clk);
        req = '0;
        #1;
        chk("en_resume_cnt", issue_cnt, 520);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #200000;
        miscompares++;
        $display("FAIL timeout observed=running expected=finished");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
